// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer: unicast or broadcast of one input word
// into per-channel one-entry slots with valid/ready handshakes and drop accounting.
module stream_demux_n #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_bcast,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic [7:0]     drop_cnt
);

  if (SW != $clog2(N) || N < 2 || N > 16 || W < 1) begin : g_param_check
    $error("stream_demux_n: need W>=1, 2<=N<=16 and SW == clog2(N)");
  end

  localparam int unsigned NCH = N;

  logic [N-1:0]         free;
  logic [(1<<SW)-1:0]   free_ext;
  logic                 sel_ok;
  logic                 xfer;
  logic                 drop;
  logic [N-1:0]         load;

  assign free   = ~out_valid | out_ready;
  assign sel_ok = 32'(in_sel) < NCH;
  assign xfer   = in_valid & in_ready;
  assign drop   = xfer & ~in_bcast & ~sel_ok;

  // Pad to the full select range so in_sel can index without going out of bounds.
  always_comb begin
    free_ext         = '0;
    free_ext[N-1:0]  = free;
  end

  always_comb begin
    in_ready = 1'b0;
    if (en) begin
      if (in_bcast)    in_ready = &free;
      else if (sel_ok) in_ready = free_ext[in_sel];
      else             in_ready = 1'b1;
    end
  end

  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      load[i] = xfer & (in_bcast | (sel_ok & (32'(in_sel) == i)));
    end
  end

  // A load wins over a drain in the same cycle, keeping valid high for back-to-back words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= '0;
      out_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (load[i]) begin
          out_valid[i]          <= 1'b1;
          out_data[i*W +: W]    <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]          <= 1'b0;
        end
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: a 4-channel and a 3-channel instance driven with directed
// and random traffic, each compared every cycle against a slot-level reference model.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       en_s   [2];
  logic       vld_s  [2];
  logic [7:0] dat_s  [2];
  logic [1:0] sel_s  [2];
  logic       bc_s   [2];
  logic [3:0] ordy_s [2];

  logic        rdy4, rdy3;
  logic [3:0]  out_valid4;
  logic [2:0]  out_valid3;
  logic [31:0] out_data4;
  logic [23:0] out_data3;
  logic [7:0]  drop4, drop3;

  stream_demux_n #(.W(8), .N(4), .SW(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en_s[0]), .in_valid(vld_s[0]), .in_ready(rdy4),
    .in_data(dat_s[0]), .in_sel(sel_s[0]), .in_bcast(bc_s[0]), .out_valid(out_valid4),
    .out_ready(ordy_s[0]), .out_data(out_data4), .drop_cnt(drop4)
  );

  stream_demux_n #(.W(8), .N(3), .SW(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en_s[1]), .in_valid(vld_s[1]), .in_ready(rdy3),
    .in_data(dat_s[1]), .in_sel(sel_s[1]), .in_bcast(bc_s[1]), .out_valid(out_valid3),
    .out_ready(ordy_s[1][2:0]), .out_data(out_data3), .drop_cnt(drop3)
  );

  // Reference model: per-instance slot contents and drop tally.
  bit         mv    [2][4];
  logic [7:0] md    [2][4];
  int         mdrop [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic model_ready(input int d);
    bit all_free;
    if (!en_s[d]) return 1'b0;
    if (bc_s[d]) begin
      all_free = 1'b1;
      for (int i = 0; i < nch(d); i++)
        if (mv[d][i] && !ordy_s[d][i]) all_free = 1'b0;
      return all_free;
    end
    if (int'(sel_s[d]) >= nch(d)) return 1'b1;
    return !mv[d][sel_s[d]] || ordy_s[d][sel_s[d]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdrop[d] = 0;
      for (int i = 0; i < 4; i++) begin
        mv[d][i] = 1'b0;
        md[d][i] = 8'h00;
      end
    end
  endtask

  task automatic model_update(input int d, input bit xfer);
    for (int i = 0; i < nch(d); i++)
      if (ordy_s[d][i]) mv[d][i] = 1'b0;
    if (xfer) begin
      if (bc_s[d]) begin
        for (int i = 0; i < nch(d); i++) begin
          mv[d][i] = 1'b1;
          md[d][i] = dat_s[d];
        end
      end else if (int'(sel_s[d]) < nch(d)) begin
        mv[d][sel_s[d]] = 1'b1;
        md[d][sel_s[d]] = dat_s[d];
      end else begin
        mdrop[d] = (mdrop[d] + 1 > 255) ? 255 : mdrop[d] + 1;
      end
    end
  endtask

  function automatic logic obs_valid(input int d, input int i);
    return (d == 0) ? out_valid4[i] : out_valid3[i];
  endfunction

  function automatic logic [7:0] obs_data(input int d, input int i);
    logic [31:0] od;
    od = (d == 0) ? out_data4 : {8'h00, out_data3};
    return od[i*8 +: 8];
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < nch(d); i++) begin
        check_eq($sformatf("d%0d.out_valid[%0d]", d, i), 32'(obs_valid(d, i)), 32'(mv[d][i]));
        check_eq($sformatf("d%0d.out_data[%0d]", d, i), 32'(obs_data(d, i)), 32'(md[d][i]));
      end
      check_eq($sformatf("d%0d.drop_cnt", d), 32'((d == 0) ? drop4 : drop3), 32'(mdrop[d]));
    end
  endtask

  task automatic step();
    logic exp_rdy [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = model_ready(d);
      check_eq($sformatf("d%0d.in_ready", d), 32'((d == 0) ? rdy4 : rdy3), 32'(exp_rdy[d]));
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_update(d, vld_s[d] && exp_rdy[d]);
    check_outputs();
  endtask

  task automatic drive(input int d, input logic e, input logic v, input logic [7:0] data,
                       input logic [1:0] sel, input logic bc, input logic [3:0] ordy);
    en_s[d]   = e;
    vld_s[d]  = v;
    dat_s[d]  = data;
    sel_s[d]  = sel;
    bc_s[d]   = bc;
    ordy_s[d] = ordy;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    idle(0);
    idle(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Four unicasts on consecutive cycles, one per channel.
    drive(0, 1, 1, 8'hA1, 2'd0, 0, 4'hF); step();
    drive(0, 1, 1, 8'hB2, 2'd1, 0, 4'hF); step();
    drive(0, 1, 1, 8'hC3, 2'd2, 0, 4'hF); step();
    drive(0, 1, 1, 8'hD4, 2'd3, 0, 4'hF); step();
    idle(0); step();

    // Stalled channel 2 blocks only itself; drain and reload in one edge.
    drive(0, 1, 1, 8'h11, 2'd2, 0, 4'b1011); step();
    drive(0, 1, 1, 8'h22, 2'd2, 0, 4'b1011); step();
    drive(0, 1, 1, 8'h33, 2'd0, 0, 4'b1011); step();
    drive(0, 1, 1, 8'h22, 2'd2, 0, 4'b1111); step();
    check_eq("drain_load_valid2", 32'(out_valid4[2]), 32'd1);
    check_eq("drain_load_data2", 32'(out_data4[23:16]), 32'h22);

    // Broadcast waits for the full channel 2, then loads every slot at once.
    drive(0, 1, 1, 8'h77, 2'd2, 0, 4'b1011); step();
    drive(0, 1, 1, 8'h5A, 2'd1, 1, 4'b1011); step();
    drive(0, 1, 1, 8'h5A, 2'd1, 1, 4'b1111); step();
    check_eq("bcast_all_valid", 32'(out_valid4), 32'hF);
    idle(0); step();

    // Out-of-range selects on the 3-channel instance saturate the drop counter.
    for (int k = 0; k < 300; k++) begin
      drive(1, 1, 1, 8'($urandom), 2'd3, 0, 4'($urandom));
      step();
    end
    check_eq("drop_saturated", 32'(drop3), 32'd255);
    check_eq("drop_no_valid", 32'(out_valid3), 32'd0);
    idle(1); step();

    // Disable with words held in channels 0 and 1; they still drain.
    drive(0, 1, 1, 8'h41, 2'd0, 0, 4'b0000); step();
    drive(0, 1, 1, 8'h42, 2'd1, 0, 4'b0000); step();
    drive(0, 0, 1, 8'h43, 2'd2, 0, 4'b0000); step();
    drive(0, 0, 1, 8'h44, 2'd2, 0, 4'b0011); step();
    check_eq("en_low_drained", 32'(out_valid4), 32'd0);

    // Randomised traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++)
        drive(d, $urandom_range(0, 7) != 0, 1'($urandom), 8'($urandom),
              2'($urandom), $urandom_range(0, 7) == 0, 4'($urandom));
      step();
    end

    // Asynchronous reset mid-stream, checked before the next clock edge.
    for (int d = 0; d < 2; d++) drive(d, 1, 1, 8'($urandom), 2'd0, 1, 4'h0);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    idle(0);
    idle(1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
